// File: rtl/kb_scancode_decoder_if.sv
// ---------------------------------------------------------------------------
// kb_scancode_decoder_if
// Byte stream from the PS/2 receive stage into the scan-code decoder, and the
// decoded key events / keyboard state coming back out.
//   i_keycode      : scan-code byte, qualified by i_ready
//   i_ready        : one-cycle strobe per received byte
//   o_key_code     : base code of the last completed event
//   o_key_extended : last event was E0-prefixed
//   o_key_break    : last event was F0-prefixed (release)
//   o_key_valid    : one-cycle strobe per completed event
//   o_ascii        : ASCII of the last printable make event
//   o_ascii_valid  : one-cycle strobe for printable make events
//   o_shift        : either Shift key held
//   o_led_status   : {Caps, Num, Scroll}
// master = byte source / event consumer, slave = decoder.
// ---------------------------------------------------------------------------
interface kb_scancode_decoder_if;
  logic [7:0] i_keycode;
  logic       i_ready;
  logic [7:0] o_key_code;
  logic       o_key_extended;
  logic       o_key_break;
  logic       o_key_valid;
  logic [7:0] o_ascii;
  logic       o_ascii_valid;
  logic       o_shift;
  logic [2:0] o_led_status;

  modport master (
    output i_keycode, i_ready,
    input  o_key_code, o_key_extended, o_key_break, o_key_valid,
           o_ascii, o_ascii_valid, o_shift, o_led_status
  );

  modport slave (
    input  i_keycode, i_ready,
    output o_key_code, o_key_extended, o_key_break, o_key_valid,
           o_ascii, o_ascii_valid, o_shift, o_led_status
  );
endinterface

// File: rtl/kb_scancode_decoder.sv
// ---------------------------------------------------------------------------
// kb_scancode_decoder
// Turns the set-2 scan-code byte stream into complete key events (base code,
// E0 flag, F0 flag), tracks Shift and the Caps/Num/Scroll lock keys, maps a
// printable subset to ASCII and drives the LED status vector.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   kb      : byte input / event output bundle (slave side)
// Parameter:
//   TIMEOUT_CYCLES : idle cycles after a prefix byte before it is dropped
// ---------------------------------------------------------------------------
module kb_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  kb_scancode_decoder_if.slave kb
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             emit, ev_ext, ev_brk;
  logic             is_e0, is_f0, is_discard;
  logic             lshift_held, rshift_held;
  logic             caps_held, num_held, scroll_held;
  logic [7:0]       key_code, ascii;
  logic             key_ext, key_brk, key_valid, ascii_valid;
  logic [2:0]       led;
  logic [8:0]       map;

  // Returns {printable, ascii}; case comes from the state before this event.
  function automatic logic [8:0] ascii_map(input logic [7:0] code,
                                           input logic shift, input logic caps);
    logic [4:0] idx;
    logic       is_letter;
    idx       = 5'd0;
    is_letter = 1'b1;
    ascii_map = 9'd0;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      ascii_map = {1'b1, ((shift ^ caps) ? 8'h41 : 8'h61) + {3'b000, idx}};
    end else begin
      case (code)
        8'h45: ascii_map = {1'b1, shift ? 8'h29 : 8'h30};
        8'h16: ascii_map = {1'b1, shift ? 8'h21 : 8'h31};
        8'h1E: ascii_map = {1'b1, shift ? 8'h40 : 8'h32};
        8'h26: ascii_map = {1'b1, shift ? 8'h23 : 8'h33};
        8'h25: ascii_map = {1'b1, shift ? 8'h24 : 8'h34};
        8'h2E: ascii_map = {1'b1, shift ? 8'h25 : 8'h35};
        8'h36: ascii_map = {1'b1, shift ? 8'h5E : 8'h36};
        8'h3D: ascii_map = {1'b1, shift ? 8'h26 : 8'h37};
        8'h3E: ascii_map = {1'b1, shift ? 8'h2A : 8'h38};
        8'h46: ascii_map = {1'b1, shift ? 8'h28 : 8'h39};
        8'h29: ascii_map = {1'b1, 8'h20};
        8'h5A: ascii_map = {1'b1, 8'h0D};
        8'h66: ascii_map = {1'b1, 8'h08};
        default: ascii_map = 9'd0;
      endcase
    end
  endfunction

  assign is_e0 = (kb.i_keycode == 8'hE0);
  assign is_f0 = (kb.i_keycode == 8'hF0);
  // Controller replies, self-test results, Pause lead-in and error codes.
  assign is_discard = (kb.i_keycode == 8'h00) || (kb.i_keycode == 8'hAA) ||
                      (kb.i_keycode == 8'hE1) || (kb.i_keycode == 8'hEE) ||
                      (kb.i_keycode == 8'hFA) || (kb.i_keycode == 8'hFE) ||
                      (kb.i_keycode == 8'hFF);

  assign map = ascii_map(kb.i_keycode, lshift_held | rshift_held, led[2]);

  // Prefix decode for the byte presented this cycle.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    if (kb.i_ready && !is_discard) begin
      case (state)
        IDLE: begin
          if (is_e0)      state_nxt = EXT;
          else if (is_f0) state_nxt = BRK;
          else            emit = 1'b1;
        end
        EXT: begin
          if (is_f0)       state_nxt = EXT_BRK;
          else if (!is_e0) begin emit = 1'b1; ev_ext = 1'b1; state_nxt = IDLE; end
        end
        BRK: begin
          if (!is_e0 && !is_f0) begin emit = 1'b1; ev_brk = 1'b1; state_nxt = IDLE; end
        end
        default: begin
          if (!is_e0 && !is_f0) begin
            emit = 1'b1; ev_ext = 1'b1; ev_brk = 1'b1; state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_brk     <= 1'b0;
      key_valid   <= 1'b0;
      ascii       <= 8'h00;
      ascii_valid <= 1'b0;
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      caps_held   <= 1'b0;
      num_held    <= 1'b0;
      scroll_held <= 1'b0;
      led         <= 3'b000;
    end else begin
      key_valid   <= 1'b0;
      ascii_valid <= 1'b0;
      if (kb.i_ready) begin
        // A byte always wins over a coincident timeout expiry.
        cnt   <= '0;
        state <= state_nxt;
        if (emit) begin
          key_code  <= kb.i_keycode;
          key_ext   <= ev_ext;
          key_brk   <= ev_brk;
          key_valid <= 1'b1;
          if (!ev_ext) begin
            case (kb.i_keycode)
              8'h12: lshift_held <= !ev_brk;
              8'h59: rshift_held <= !ev_brk;
              // Lock LEDs toggle only on the first make, not typematic repeats.
              8'h58: begin
                if (!ev_brk && !caps_held) led[2] <= ~led[2];
                caps_held <= !ev_brk;
              end
              8'h77: begin
                if (!ev_brk && !num_held) led[1] <= ~led[1];
                num_held <= !ev_brk;
              end
              8'h7E: begin
                if (!ev_brk && !scroll_held) led[0] <= ~led[0];
                scroll_held <= !ev_brk;
              end
              default: ;
            endcase
            if (!ev_brk && map[8]) begin
              ascii       <= map[7:0];
              ascii_valid <= 1'b1;
            end
          end
        end
      end else if (state != IDLE) begin
        if (cnt == CNT_LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign kb.o_key_code     = key_code;
  assign kb.o_key_extended = key_ext;
  assign kb.o_key_break    = key_brk;
  assign kb.o_key_valid    = key_valid;
  assign kb.o_ascii        = ascii;
  assign kb.o_ascii_valid  = ascii_valid;
  assign kb.o_shift        = lshift_held | rshift_held;
  assign kb.o_led_status   = led;

endmodule

// File: tb/tb_kb_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_kb_scancode_decoder
// Directed byte sequences into kb_scancode_decoder with hand-derived expected
// events, ASCII, Shift and LED state. Inputs change on the falling edge and
// outputs are sampled on the falling edge after the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_kb_scancode_decoder;

  localparam int T = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] last_asc = 8'h00;

  always #5 clk = ~clk;

  kb_scancode_decoder_if kb ();

  kb_scancode_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .kb      (kb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: presents the byte for one rising edge and
  // returns at the next falling edge, where the resulting outputs are visible.
  task automatic send(input logic [7:0] b);
    kb.i_keycode = b;
    kb.i_ready   = 1'b1;
    @(negedge clk);
    kb.i_ready   = 1'b0;
  endtask

  task automatic no_ev(input string tag);
    chk({tag, ".valid"}, 32'(kb.o_key_valid), 32'd0);
  endtask

  task automatic ev(input string tag, input logic [7:0] code, input logic ext,
                    input logic brk, input logic av, input logic [7:0] asc);
    if (av) last_asc = asc;
    chk({tag, ".valid"}, 32'(kb.o_key_valid), 32'd1);
    chk({tag, ".code"},  32'(kb.o_key_code), 32'(code));
    chk({tag, ".ext"},   32'(kb.o_key_extended), 32'(ext));
    chk({tag, ".brk"},   32'(kb.o_key_break), 32'(brk));
    chk({tag, ".av"},    32'(kb.o_ascii_valid), 32'(av));
    chk({tag, ".ascii"}, 32'(kb.o_ascii), 32'(last_asc));
  endtask

  function automatic logic [23:0] all_out();
    return {kb.o_key_code, kb.o_key_extended, kb.o_key_break, kb.o_key_valid,
            kb.o_ascii, kb.o_ascii_valid, kb.o_shift, kb.o_led_status};
  endfunction

  initial begin
    int seen;
    kb.i_keycode = 8'h00;
    kb.i_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(all_out()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain make / break
    send(8'h1C); ev("a_make", 8'h1C, 0, 0, 1, 8'h61);
    send(8'hF0); no_ev("f0_prefix");
    send(8'h1C); ev("a_break", 8'h1C, 0, 1, 0, 8'h00);
    send(8'h1C); ev("b2b_a", 8'h1C, 0, 0, 1, 8'h61);
    send(8'h32); ev("b2b_b", 8'h32, 0, 0, 1, 8'h62);

    // Shift
    send(8'h12); ev("lshift_make", 8'h12, 0, 0, 0, 8'h00);
    chk("shift_on", 32'(kb.o_shift), 32'd1);
    send(8'h1C); ev("shift_A", 8'h1C, 0, 0, 1, 8'h41);
    send(8'h16); ev("shift_1", 8'h16, 0, 0, 1, 8'h21);
    send(8'h1E); ev("shift_2", 8'h1E, 0, 0, 1, 8'h40);
    send(8'hF0); send(8'h12); ev("lshift_break", 8'h12, 0, 1, 0, 8'h00);
    chk("shift_off", 32'(kb.o_shift), 32'd0);
    send(8'h1C); ev("unshift_a", 8'h1C, 0, 0, 1, 8'h61);
    send(8'h59); chk("rshift_on", 32'(kb.o_shift), 32'd1);
    send(8'h45); ev("shift_0", 8'h45, 0, 0, 1, 8'h29);
    send(8'h29); ev("shift_space", 8'h29, 0, 0, 1, 8'h20);
    send(8'hF0); send(8'h59); chk("rshift_off", 32'(kb.o_shift), 32'd0);
    send(8'h46); ev("digit_9", 8'h46, 0, 0, 1, 8'h39);

    // Caps lock with typematic repeats
    send(8'h58); chk("caps_first", 32'(kb.o_led_status), 32'h4);
    send(8'h58); chk("caps_rep1", 32'(kb.o_led_status), 32'h4);
    send(8'h58); chk("caps_rep2", 32'(kb.o_led_status), 32'h4);
    send(8'hF0); send(8'h58); chk("caps_rel", 32'(kb.o_led_status), 32'h4);
    send(8'h58); chk("caps_second", 32'(kb.o_led_status), 32'h0);
    send(8'hF0); send(8'h58);
    send(8'h58); chk("caps_third", 32'(kb.o_led_status), 32'h4);
    send(8'hF0); send(8'h58);
    send(8'h1C); ev("caps_A", 8'h1C, 0, 0, 1, 8'h41);
    send(8'h5A); ev("caps_enter", 8'h5A, 0, 0, 1, 8'h0D);
    send(8'h12);
    send(8'h1C); ev("caps_shift_a", 8'h1C, 0, 0, 1, 8'h61);
    send(8'hF0); send(8'h12);
    send(8'h77); chk("num_on", 32'(kb.o_led_status), 32'h6);
    send(8'hF0); send(8'h77);
    send(8'h77); chk("num_off", 32'(kb.o_led_status), 32'h4);
    send(8'hF0); send(8'h77);
    send(8'h7E); chk("scroll_on", 32'(kb.o_led_status), 32'h5);
    send(8'hF0); send(8'h7E);
    send(8'h7E); chk("scroll_off", 32'(kb.o_led_status), 32'h4);
    send(8'hF0); send(8'h7E);
    send(8'hE0); send(8'h58); ev("ext_58", 8'h58, 1, 0, 0, 8'h00);
    chk("ext_58_led", 32'(kb.o_led_status), 32'h4);

    // Extended events
    send(8'hE0); no_ev("e0_prefix");
    send(8'hF0); no_ev("e0f0_prefix");
    send(8'h75); ev("ext_brk_75", 8'h75, 1, 1, 0, 8'h00);
    send(8'hE0); send(8'h5A); ev("ext_enter", 8'h5A, 1, 0, 0, 8'h00);
    send(8'hE0); send(8'hE0); send(8'h1C); ev("e0_e0_1c", 8'h1C, 1, 0, 0, 8'h00);
    send(8'hF0); send(8'hE0); send(8'hF0); send(8'h1C);
    ev("brk_repeat_prefix", 8'h1C, 0, 1, 0, 8'h00);
    send(8'hE0); send(8'hF0); send(8'hE0); send(8'h75);
    ev("extbrk_repeat", 8'h75, 1, 1, 0, 8'h00);

    // Discarded bytes
    send(8'hAA); no_ev("disc_aa");
    send(8'hFA); no_ev("disc_fa");
    send(8'hE0); send(8'hAA); no_ev("disc_in_ext");
    send(8'h5A); ev("ext_after_disc", 8'h5A, 1, 0, 0, 8'h00);

    // Byte coincident with timeout expiry is still extended
    send(8'hE0);
    seen = 0;
    repeat (T - 1) begin
      @(negedge clk);
      if (kb.o_key_valid) seen++;
    end
    send(8'h5A); ev("tmo_boundary", 8'h5A, 1, 0, 0, 8'h00);
    chk("tmo_boundary_quiet", 32'(seen), 32'd0);

    // Prefix expires after a full timeout
    send(8'hE0);
    seen = 0;
    repeat (T) begin
      @(negedge clk);
      if (kb.o_key_valid) seen++;
    end
    chk("tmo_no_event", 32'(seen), 32'd0);
    send(8'h29); ev("tmo_space", 8'h29, 0, 0, 1, 8'h20);

    // Reset in the middle of a prefix with Caps LED on
    chk("pre_rst_caps", 32'(kb.o_led_status), 32'h4);
    send(8'hE0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'(all_out()), 32'd0);
    @(negedge clk);
    chk("mid_rst_hold", 32'(all_out()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    last_asc = 8'h00;
    send(8'h1C); ev("post_rst_a", 8'h1C, 0, 0, 1, 8'h61);
    chk("post_rst_led", 32'(kb.o_led_status), 32'h0);
    @(negedge clk);
    chk("strobe_width", 32'({kb.o_key_valid, kb.o_ascii_valid}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
